// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear to 0, load to 1, or increment with wrap from 3 to 0.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load1,
  input  logic  clr,
  output slot_t cnt
);

  slot_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = slot_t'(1);
    end else if (inc) begin
      cnt_d = (cnt_q == slot_t'(NUM_SLOTS - 1)) ? '0 : cnt_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: hunts for fsync, stages a frame, and publishes
// all four channels together when slot 3 arrives.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         fsync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         frame_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err
);

  state_e       state_q, state_d;
  logic [W-1:0] stage_q [NUM_SLOTS];
  logic [W-1:0] stage_d [NUM_SLOTS];
  logic [W-1:0] y_q     [NUM_SLOTS];
  logic [W-1:0] y_d     [NUM_SLOTS];
  logic         fv_q, fv_d;
  logic         se_q, se_d;
  logic         inc, load1, clr;
  slot_t        cnt;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .load1 (load1),
    .clr   (clr),
    .cnt   (cnt)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    inc     = 1'b0;
    load1   = 1'b0;
    clr     = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            stage_d[0] = din;
            load1      = 1'b1;
            state_d    = LOCKED;
          end
        end
        LOCKED: begin
          if (fsync) begin
            // Early sync restarts the frame; stale staging is overwritten before reuse.
            se_d       = (cnt != '0);
            stage_d[0] = din;
            load1      = 1'b1;
          end else if (cnt == '0) begin
            se_d    = 1'b1;
            clr     = 1'b1;
            state_d = HUNT;
          end else begin
            stage_d[cnt] = din;
            inc          = 1'b1;
            if (cnt == slot_t'(NUM_SLOTS - 1)) begin
              y_d  = stage_d;
              fv_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stage_q[i] <= '0;
        y_q[i]     <= '0;
      end
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      stage_q <= stage_d;
      y_q     <= y_d;
    end
  end

  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign slot        = cnt;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed table, corner sequences, and
// randomized traffic against a queue-based frame model.
module tb_tdm_demux4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         fsync = 1'b0;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid, sync_err, locked;
  logic [1:0]   slot;

  int n_checks = 0;
  int n_errors = 0;

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .fsync       (fsync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a queue of accepted samples since the last fsync.
  logic         m_locked;
  logic [W-1:0] m_frame [$];
  logic [W-1:0] m_y [4];
  logic         m_fv, m_se;

  task automatic model_reset();
    m_locked = 1'b0;
    m_frame.delete();
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    m_fv = 1'b0;
    m_se = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic f, input logic [W-1:0] d);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (f) begin
          m_frame.delete();
          m_frame.push_back(d);
          m_locked = 1'b1;
        end
      end else if (f) begin
        if (m_frame.size() != 0) m_se = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
      end else if (m_frame.size() == 0) begin
        m_se     = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 4) begin
          for (int i = 0; i < 4; i++) m_y[i] = m_frame[i];
          m_fv = 1'b1;
          m_frame.delete();
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".y"}, 32'({y3, y2, y1, y0}), 32'({m_y[3], m_y[2], m_y[1], m_y[0]}));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_se));
    chk({tag, ".slot"}, 32'(slot), 32'(m_frame.size() % 4));
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic v, input logic f, input logic [W-1:0] d);
    din_valid = v;
    fsync     = f;
    din       = d;
    @(posedge clk);
    model_step(v, f, d);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that clearing is immediate.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(negedge clk);
    compare_all({tag, ".held"});
    rst = 1'b0;
  endtask

  typedef struct {
    logic         v;
    logic         f;
    logic [W-1:0] d;
    logic [15:0]  ey;
    logic         efv;
    logic         ese;
    logic [1:0]   eslot;
    logic         elk;
  } vec_t;

  vec_t tab [14];
  int   fv_count;

  initial begin
    tab[0]  = '{1'b1, 1'b1, 4'h1, 16'h0000, 1'b0, 1'b0, 2'd1, 1'b1};
    tab[1]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b1};
    tab[2]  = '{1'b1, 1'b0, 4'h1, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1};
    tab[3]  = '{1'b1, 1'b0, 4'h0, 16'h0101, 1'b1, 1'b0, 2'd0, 1'b1};
    tab[4]  = '{1'b0, 1'b1, 4'h5, 16'h0101, 1'b0, 1'b0, 2'd0, 1'b1};
    tab[5]  = '{1'b1, 1'b1, 4'h0, 16'h0101, 1'b0, 1'b0, 2'd1, 1'b1};
    tab[6]  = '{1'b1, 1'b0, 4'h1, 16'h0101, 1'b0, 1'b0, 2'd2, 1'b1};
    tab[7]  = '{1'b1, 1'b1, 4'h1, 16'h0101, 1'b0, 1'b1, 2'd1, 1'b1};
    tab[8]  = '{1'b1, 1'b0, 4'h2, 16'h0101, 1'b0, 1'b0, 2'd2, 1'b1};
    tab[9]  = '{1'b1, 1'b0, 4'h3, 16'h0101, 1'b0, 1'b0, 2'd3, 1'b1};
    tab[10] = '{1'b1, 1'b0, 4'h4, 16'h4321, 1'b1, 1'b0, 2'd0, 1'b1};
    tab[11] = '{1'b1, 1'b0, 4'h7, 16'h4321, 1'b0, 1'b1, 2'd0, 1'b0};
    tab[12] = '{1'b1, 1'b0, 4'h6, 16'h4321, 1'b0, 1'b0, 2'd0, 1'b0};
    tab[13] = '{1'b1, 1'b1, 4'h8, 16'h4321, 1'b0, 1'b0, 2'd1, 1'b1};

    model_reset();
    @(negedge clk);
    do_reset("init");

    // Directed table: basic frame, ignored fsync, early sync, missing sync.
    for (int i = 0; i < 14; i++) begin
      cycle(tab[i].v, tab[i].f, tab[i].d);
      chk($sformatf("tab%0d.y", i), 32'({y3, y2, y1, y0}), 32'(tab[i].ey));
      chk($sformatf("tab%0d.fv", i), 32'(frame_valid), 32'(tab[i].efv));
      chk($sformatf("tab%0d.se", i), 32'(sync_err), 32'(tab[i].ese));
      chk($sformatf("tab%0d.slot", i), 32'(slot), 32'(tab[i].eslot));
      chk($sformatf("tab%0d.locked", i), 32'(locked), 32'(tab[i].elk));
    end

    // Frame 1,0,1,0 with 3-cycle gaps between samples.
    do_reset("gap");
    fv_count = 0;
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, (s == 0), (s % 2 == 0) ? 4'h1 : 4'h0);
      if (frame_valid) fv_count++;
      compare_all("gap.sample");
      if (s != 3) begin
        for (int g = 0; g < 3; g++) begin
          cycle(1'b0, 1'b1, 4'hF);
          if (frame_valid) fv_count++;
          compare_all("gap.idle");
        end
      end
    end
    cycle(1'b0, 1'b0, 4'h0);
    if (frame_valid) fv_count++;
    chk("gap.fv_count", 32'(fv_count), 32'd1);
    chk("gap.y", 32'({y3, y2, y1, y0}), 32'h0101);
    chk("gap.locked", 32'(locked), 32'd1);

    // HUNT: four valid samples without fsync are discarded.
    do_reset("hunt");
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, 1'b0, 4'hF);
      compare_all("hunt");
    end
    chk("hunt.y_zero", 32'({y3, y2, y1, y0}), 32'h0);
    chk("hunt.locked", 32'(locked), 32'd0);

    // Reset mid-frame after slot 2 with valid still asserted.
    cycle(1'b1, 1'b1, 4'h9);
    cycle(1'b1, 1'b0, 4'h8);
    cycle(1'b1, 1'b0, 4'h7);
    cycle(1'b1, 1'b0, 4'h6);
    chk("midrst.prev_y", 32'({y3, y2, y1, y0}), 32'h6789);
    cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b1, 1'b0, 4'h2);
    cycle(1'b1, 1'b0, 4'h3);
    din_valid = 1'b1;
    fsync     = 1'b0;
    din       = 4'h4;
    do_reset("midrst");
    chk("midrst.y_zero", 32'({y3, y2, y1, y0}), 32'h0);
    chk("midrst.fv", 32'(frame_valid), 32'd0);
    cycle(1'b1, 1'b0, 4'h5);
    compare_all("midrst.after");
    chk("midrst.hunt", 32'(locked), 32'd0);
    cycle(1'b1, 1'b1, 4'h5);
    compare_all("midrst.relock");

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand.rst");
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
              W'($urandom));
        compare_all("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, default 1, width of each data slot and channel output.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  W  time-multiplexed sample for the current slot.
REQ-005 Port: din_valid  input  1  din carries a sample this cycle.
REQ-006 Port: fsync  input  1  qualified by din_valid; marks the sample as slot 0 of a frame.
REQ-007 Port: y0, y1, y2, y3  output  W each  demultiplexed channel registers, updated once per complete frame.
REQ-008 Port: frame_valid  output  1  one-cycle pulse when y0..y3 take a new frame.
REQ-009 Port: slot  output  2  next expected slot index, s1 = slot[1], s0 = slot[0].
REQ-010 Port: locked  output  1  high while in state LOCKED.
REQ-011 Port: sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 A sample is accepted only on a cycle with din_valid=1; fsync with din_valid=0 SHALL be ignored.
REQ-013 States SHALL be HUNT and LOCKED.
REQ-014 In HUNT, an accepted sample with fsync=0 SHALL be discarded with no output change.
REQ-015 In HUNT, an accepted sample with fsync=1 SHALL be stored as slot 0, set slot=1 and move to LOCKED.
REQ-016 In LOCKED, an accepted sample with fsync=0 and slot!=0 SHALL be stored in staging register [slot], and slot SHALL increment.
REQ-017 In LOCKED, an accepted sample with fsync=1 and slot=0 SHALL be stored as slot 0 and set slot=1.
REQ-018 Storing slot 3 SHALL wrap slot to 0 and copy all four staging registers to y0..y3 together.
REQ-019 y0..y3 and frame_valid SHALL both become visible on the clock edge that accepts the slot-3 sample.
REQ-020 y0..y3 SHALL hold their values between frames.
REQ-021 In LOCKED, fsync=1 with slot!=0 (early sync) SHALL have the following effects:
- sync_err pulses.
- The partial frame is discarded.
- The sample is stored as slot 0 and slot becomes 1.
- The state remains LOCKED.
REQ-022 In LOCKED, an accepted sample with fsync=0 and slot=0 (missing sync) SHALL have the following effects:
- sync_err pulses.
- The sample is discarded.
- The state becomes HUNT and slot becomes 0.
REQ-023 Staging registers for a discarded partial frame SHALL never reach y0..y3.
REQ-024 Gaps (din_valid=0) of any length inside a frame SHALL NOT affect state, slot or staging.
REQ-025 frame_valid and sync_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.

Reset
REQ-026 On rst=1, the following SHALL happen immediately and asynchronously:
- The state becomes HUNT.
- slot becomes 0.
- The staging registers and y0..y3 become 0.
- frame_valid, sync_err and locked become 0.
REQ-027 When reset is asserted mid-frame, the partial frame SHALL be lost and y0..y3 SHALL read 0.
REQ-028 The first edge after rst deasserts SHALL be processed per REQ-014/015.

Structure
REQ-029 A shared package tdm_pkg SHALL hold the following:
- The state enum (HUNT, LOCKED).
- NUM_SLOTS = 4.
- The 2-bit slot index type.
REQ-030 The slot index logic SHALL be a sub-module, tdm_slot_ctr. It has the following inputs and output:
- Input inc.
- Input load1, which sets the count to 1.
- Input clr, which sets the count to 0.
- Output cnt, which wraps 3 to 0.
REQ-031 The top level SHALL contain the FSM, the staging registers and the output registers.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Reset, then fsync+valid with din sequence 1,0,1,0 (W=1) in four consecutive cycles -> y0=1, y1=0, y2=1, y3=0 and one frame_valid pulse on the 4th accepting edge; locked=1.
- Frame 1,0,1,0 with din_valid=0 gaps of 3 cycles between samples -> same outputs; frame_valid exactly once.
- Locked, samples 0,1 then fsync+valid with 1 at slot 2 -> sync_err pulse, y unchanged, slot=1, locked=1.
- Locked after a full frame, then valid with fsync=0 at slot 0 -> sync_err pulse, locked=0, slot=0; later samples ignored until fsync.
- In HUNT, four valid samples without fsync -> no frame_valid, y stays 0, locked=0.
- Reset asserted after slot 2 of a frame, while valid continues -> y0..y3=0 at once, no frame_valid, HUNT.
